// File: rtl/spi_bus_bridge_pkg.sv
// Shared definitions for the SPI-to-bus bridge: frame constants and FSM states.
package spi_bus_bridge_pkg;

  // Command byte width and the bit that selects write (1) or read (0).
  localparam int CMD_W      = 8;
  localparam int CMD_WR_BIT = 7;

  // Frame-level FSM states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    WDATA = 3'd3,
    RWAIT = 3'd4,
    RDATA = 3'd5,
    DRAIN = 3'd6
  } state_t;

  // Largest of three widths; sizes the shared bit counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_bus_bridge_sync.sv
// Multi-flop synchronizer with rising/falling edge detection for one SPI pin.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  // fill_q fills with ones after reset; edges are reported only once both the
  // synchronized value and its delayed copy reflect the real pin, so a pin that
  // already differs from its reset value does not look like a fresh edge.
  logic [STAGES:0]   fill_q, fill_d;

  // Next-state for the shift chain, the edge-detect copy and the fill marker.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
    fill_d = {fill_q[STAGES-1:0], 1'b1};
  end

  // Synchronizer flops, preset to the idle level of the pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      fill_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      fill_q <= fill_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = fill_q[STAGES] &  dout & ~prev_q;
  assign fall = fill_q[STAGES] & ~dout &  prev_q;

endmodule

// File: rtl/spi_bus_bridge.sv
// SPI mode-0 slave that turns each cmd/addr/data frame into one bus write or read.
module spi_bus_bridge
  import spi_bus_bridge_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs,
  output logic              miso,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rvalid,
  output logic              rd_late
);

  localparam int CNT_W = $clog2(max3(CMD_W, ADDR_W, DATA_W) + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic cs_s, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk (clk), .rst (reset), .din (sclk),
    .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk), .rst (reset), .din (mosi),
    .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk (clk), .rst (reset), .din (cs),
    .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
  // Receives write data, and later holds read data being shifted out on miso.
  logic [DATA_W-1:0] data_sh_q, data_sh_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              bus_we_q, bus_we_d;
  logic              bus_re_q, bus_re_d;
  logic              miso_q, miso_d;
  logic              rd_late_q, rd_late_d;

  logic [ADDR_W-1:0] addr_shift_in;
  logic [DATA_W-1:0] data_shift_in;

  assign addr_shift_in = {addr_sh_q[ADDR_W-2:0], mosi_s};
  assign data_shift_in = {data_sh_q[DATA_W-2:0], mosi_s};

  // Edges that the frame logic does not need, plus the shift-register MSB that
  // only ever falls off the end.
  logic unused_sigs;
  assign unused_sigs = ^{sclk_s, mosi_rise, mosi_fall, cs_rise, data_sh_q[DATA_W-1]};

  // Frame FSM: counts sclk rising edges per phase and issues at most one strobe.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_wr_d    = cmd_wr_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_we_d    = 1'b0;
    bus_re_d    = 1'b0;
    miso_d      = miso_q;
    rd_late_d   = rd_late_q;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = CMD;
          cnt_d   = '0;
        end
      end

      CMD: begin
        if (sclk_rise) begin
          if (cnt_q == CNT_W'(CMD_W - 1 - CMD_WR_BIT)) begin
            cmd_wr_d = mosi_s;
          end
          if (cnt_q == CNT_W'(CMD_W - 1)) begin
            cnt_d   = '0;
            state_d = ADDR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ADDR: begin
        if (sclk_rise) begin
          addr_sh_d = addr_shift_in;
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            cnt_d = '0;
            if (cmd_wr_q) begin
              state_d = WDATA;
            end else begin
              // Read request goes out now so data has the whole gap before
              // the first data edge to come back.
              bus_addr_d = addr_shift_in;
              bus_re_d   = 1'b1;
              state_d    = RWAIT;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      WDATA: begin
        if (sclk_rise) begin
          data_sh_d = data_shift_in;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            bus_addr_d  = addr_sh_q;
            bus_wdata_d = data_shift_in;
            bus_we_d    = 1'b1;
            cnt_d       = '0;
            state_d     = DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      RWAIT: begin
        // The master already sampled miso on this edge, so the data is lost:
        // flag it and clock out zeros for the rest of the data phase.
        if (sclk_rise) begin
          rd_late_d = 1'b1;
          data_sh_d = '0;
          miso_d    = 1'b0;
          cnt_d     = CNT_W'(1);
          state_d   = RDATA;
        end else if (bus_rvalid) begin
          data_sh_d = bus_rdata;
          miso_d    = bus_rdata[DATA_W-1];
          cnt_d     = '0;
          state_d   = RDATA;
        end
      end

      RDATA: begin
        if (sclk_rise) begin
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            miso_d  = 1'b0;
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (sclk_fall && (cnt_q != '0)) begin
          // Falls before the first data edge (the tail of the address bit)
          // must not shift away the preloaded MSB.
          data_sh_d = {data_sh_q[DATA_W-2:0], 1'b0};
          miso_d    = data_sh_q[DATA_W-2];
        end
      end

      DRAIN: begin
        state_d = DRAIN;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Deselect aborts the frame. A write strobe computed this same cycle
    // belongs to a complete frame and is kept; a read strobe is dropped.
    if (cs_s && (state_q != IDLE)) begin
      state_d  = IDLE;
      cnt_d    = '0;
      miso_d   = 1'b0;
      bus_re_d = 1'b0;
    end
  end

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_wr_q    <= 1'b0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_we_q    <= 1'b0;
      bus_re_q    <= 1'b0;
      miso_q      <= 1'b0;
      rd_late_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_wr_q    <= cmd_wr_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_we_q    <= bus_we_d;
      bus_re_q    <= bus_re_d;
      miso_q      <= miso_d;
      rd_late_q   <= rd_late_d;
    end
  end

  assign miso      = miso_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_we    = bus_we_q;
  assign bus_re    = bus_re_q;
  assign rd_late   = rd_late_q;

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Bench for spi_bus_bridge: table of full frames plus abort/reset/late-read sequences.
module tb_spi_bus_bridge;
  import spi_bus_bridge_pkg::*;

  localparam int HALF = 4;  // sclk half period in clk cycles (sclk = clk/8)

  logic        clk = 1'b0;
  logic        reset;
  logic        sclk, mosi, cs;
  logic        miso;
  logic [15:0] bus_addr, bus_wdata;
  logic        bus_we, bus_re;
  logic [15:0] bus_rdata;
  logic        bus_rvalid;
  logic        rd_late;

  int checks = 0;
  int errors = 0;

  int          rsp_delay = 3;
  logic [15:0] rsp_data  = '0;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [15:0] data;
    int          delay;
    logic [15:0] exp_rx;
    logic        exp_late;
  } vec_t;
  vec_t vecs[5];

  spi_bus_bridge #(.ADDR_W(16), .DATA_W(16), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs        (cs),
    .miso      (miso),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .bus_rvalid(bus_rvalid),
    .rd_late   (rd_late)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one mode-0 frame; only the first nbits are sent. rx collects the
  // miso bits seen at the sclk rising edges of the data phase.
  task automatic spi_frame(input logic [7:0] cmd, input logic [15:0] addr,
                           input logic [15:0] data, input int nbits,
                           input bit keep_cs, output logic [15:0] rx);
    logic [39:0] fr;
    fr = {cmd, addr, data};
    rx = '0;
    @(negedge clk);
    cs = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = fr[39-i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      if (i >= 24) rx = {rx[14:0], miso};
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    mosi = 1'b0;
    repeat (HALF) @(negedge clk);
    if (!keep_cs) begin
      cs = 1'b1;
      repeat (4 * HALF) @(negedge clk);
    end
  endtask

  // Bus slave: answers each read strobe rsp_delay cycles later.
  initial begin
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    forever begin
      @(negedge clk);
      if (bus_re) begin
        repeat (rsp_delay - 1) @(negedge clk);
        bus_rdata  = rsp_data;
        bus_rvalid = 1'b1;
        @(negedge clk);
        bus_rvalid = 1'b0;
      end
    end
  end

  // Scoreboard: every strobe must match the oldest expected transaction.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_we && bus_re) begin
        checks++;
        errors++;
        $display("FAIL strobe_overlap actual=we&re required=one");
      end
      if (bus_we || bus_re) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe actual=we%0b re%0b addr=%h required=none",
                   bus_we, bus_re, bus_addr);
        end else begin
          e = exp_q.pop_front();
          if ((bus_we !== e.wr) || (bus_addr !== e.addr) ||
              (e.wr && (bus_wdata !== e.data))) begin
            errors++;
            $display("FAIL bus_txn actual=we%0b addr=%h wdata=%h required=we%0b addr=%h wdata=%h",
                     bus_we, bus_addr, bus_wdata, e.wr, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rx;
    exp_t        x;

    vecs[0] = '{8'h80, 16'h1234, 16'hBEEF, 1, 16'h0000, 1'b0};
    vecs[1] = '{8'h00, 16'h5555, 16'hA5C3, 3, 16'hA5C3, 1'b0};
    vecs[2] = '{8'hFF, 16'h0F0F, 16'h3C96, 1, 16'h0000, 1'b0};
    vecs[3] = '{8'h7F, 16'h0F0F, 16'h6E21, 1, 16'h6E21, 1'b0};
    vecs[4] = '{8'h00, 16'hFFFF, 16'h8001, 4, 16'h8001, 1'b0};

    reset = 1'b1;
    cs    = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(miso), 0);
    check("rst_we_re", 32'({bus_we, bus_re}), 0);
    check("rst_addr_wdata", {bus_addr, bus_wdata}, 0);
    check("rst_late", 32'(rd_late), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Full frames, back to back with two sclk periods of deselect between.
    for (int i = 0; i < 5; i++) begin
      x.wr   = vecs[i].cmd[7];
      x.addr = vecs[i].addr;
      x.data = vecs[i].data;
      exp_q.push_back(x);
      rsp_delay = vecs[i].delay;
      rsp_data  = vecs[i].data;
      spi_frame(vecs[i].cmd, vecs[i].addr, vecs[i].data, 40, 1'b0, rx);
      check($sformatf("vec%0d_rx", i), 32'(rx), 32'(vecs[i].exp_rx));
      check($sformatf("vec%0d_late", i), 32'(rd_late), 32'(vecs[i].exp_late));
    end
    check("wr_hold_addr", 32'(bus_addr), 32'h0000FFFF);
    check("wr_hold_wdata", 32'(bus_wdata), 32'h00003C96);

    // Deselect after 20 bits of a write: no strobe, back to idle.
    spi_frame(8'h80, 16'hABCD, 16'h1111, 20, 1'b0, rx);
    check("abort_idle", 32'(dut.state_q), 32'(IDLE));
    check("abort_miso", 32'(miso), 0);
    x = '{1'b1, 16'h0001, 16'h0002};
    exp_q.push_back(x);
    spi_frame(8'h80, 16'h0001, 16'h0002, 40, 1'b0, rx);
    check("after_abort_addr", 32'(bus_addr), 32'h0001);
    check("after_abort_wdata", 32'(bus_wdata), 32'h0002);

    // Reset in the middle of the address phase, cs held low across it.
    spi_frame(8'h80, 16'h4321, 16'h9999, 14, 1'b1, rx);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_addr_wdata", {bus_addr, bus_wdata}, 0);
    check("midrst_strobes_miso_late", 32'({bus_we, bus_re, miso, rd_late}), 0);
    check("midrst_state", 32'(dut.state_q), 32'(IDLE));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 26; i++) begin
      mosi = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    mosi = 1'b0;
    check("no_fresh_fall_idle", 32'(dut.state_q), 32'(IDLE));
    cs = 1'b1;
    repeat (4 * HALF) @(negedge clk);
    x = '{1'b1, 16'h00A5, 16'h5A00};
    exp_q.push_back(x);
    spi_frame(8'h80, 16'h00A5, 16'h5A00, 40, 1'b0, rx);
    check("post_rst_wdata", 32'(bus_wdata), 32'h5A00);
    x = '{1'b0, 16'h00A5, 16'h0000};
    exp_q.push_back(x);
    rsp_delay = 2;
    rsp_data  = 16'h5A00;
    spi_frame(8'h00, 16'h00A5, 16'h0000, 40, 1'b0, rx);
    check("post_rst_rx", 32'(rx), 32'h5A00);

    // Read data withheld past the first data edge.
    x = '{1'b0, 16'h0BAD, 16'h0000};
    exp_q.push_back(x);
    rsp_delay = 40;
    rsp_data  = 16'hFFFF;
    spi_frame(8'h00, 16'h0BAD, 16'h0000, 40, 1'b0, rx);
    check("late_rx", 32'(rx), 32'h0000);
    check("late_flag", 32'(rd_late), 1);
    x = '{1'b0, 16'h1234, 16'h0000};
    exp_q.push_back(x);
    rsp_delay = 2;
    rsp_data  = 16'h7777;
    spi_frame(8'h00, 16'h1234, 16'h0000, 40, 1'b0, rx);
    check("after_late_rx", 32'(rx), 32'h7777);
    check("late_sticky", 32'(rd_late), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("late_cleared", 32'(rd_late), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_bus_bridge.md
SPI_BUS_BRIDGE -- requirements
Module: spi_bus_bridge

Interface
REQ-001 Parameter ADDR_W, default 16, bus address width.
REQ-002 Parameter DATA_W, default 16, bus data width.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer depth for sclk/mosi/cs (minimum 2).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk, frequency at most clk/8.
REQ-007 mosi  input  1  SPI serial data in, MSB first.
REQ-008 cs  input  1  SPI chip select, active-low.
REQ-009 miso  output  1  SPI serial data out, MSB first.
REQ-010 bus_addr  output  ADDR_W  bus address.
REQ-011 bus_wdata  output  DATA_W  bus write data.
REQ-012 bus_we  output  1  one-cycle write strobe.
REQ-013 bus_re  output  1  one-cycle read strobe.
REQ-014 bus_rdata  input  DATA_W  read data, qualified by bus_rvalid.
REQ-015 bus_rvalid  input  1  one-cycle read-data-valid pulse.
REQ-016 rd_late  output  1  sticky flag: read data arrived too late; cleared only by reset.

Function
REQ-017 sclk, mosi and cs SHALL pass through SYNC_STAGES flops; edges SHALL be detected on synchronized sclk.
REQ-018 Frame format: 8-bit command, then ADDR_W address bits, then DATA_W data bits; command bit 7 = 1 means write, 0 means read; command bits 6:0 ignored.
REQ-019 mosi SHALL be sampled on a synchronized sclk rising edge; miso SHALL change only on a synchronized sclk falling edge, except for the MSB preload in REQ-024.
REQ-020 FSM states: IDLE, CMD, ADDR, WDATA, RWAIT, RDATA, DRAIN.
REQ-021 IDLE->CMD on synchronized cs falling; CMD->ADDR after 8 bits; ADDR->WDATA (write) or RWAIT (read) after ADDR_W bits.
REQ-022 Write: after the last WDATA bit, bus_addr/bus_wdata SHALL be valid and bus_we SHALL pulse for exactly one cycle, no more than 2 clk cycles after that sclk edge is detected; state then goes to DRAIN.
REQ-023 Read: on RWAIT entry, bus_re SHALL pulse for one cycle with bus_addr valid; bus_addr SHALL stay stable until bus_rvalid or frame end.
REQ-024 On bus_rvalid in RWAIT: latch bus_rdata into the shift register, drive the MSB on miso immediately, and go to RDATA.
REQ-025 If the first data-phase sclk rising edge arrives while in RWAIT: set rd_late, shift zeros for all DATA_W bits, and ignore any later bus_rvalid.
REQ-026 RDATA shifts DATA_W bits, then goes to DRAIN; DRAIN holds until cs deasserts and ignores further sclk edges.
REQ-027 cs deassertion in any state SHALL return the FSM to IDLE within 1 cycle after synchronization, clear bit counters, and drive miso 0; no bus strobe SHALL be issued for an incomplete frame.
REQ-028 If cs deasserts and bus_we is due in the same cycle, the write SHALL still complete; the frame counts as complete.
REQ-029 bus_we and bus_re SHALL never be asserted together; at most one strobe per frame.
REQ-030 miso SHALL be 0 whenever no read data is being shifted.

Reset
REQ-031 On reset assertion, immediately: FSM = IDLE; miso, bus_we, bus_re, rd_late = 0; bus_addr, bus_wdata, shift register and counters = 0; synchronizer flops = sclk 0, mosi 0, cs 1.
REQ-032 Reset asserted mid-frame SHALL discard the frame; after release, the bridge SHALL wait for a fresh cs falling edge.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the command-bit index constant (7), and the CMD_W=8 constant.
REQ-034 The synchronizer + edge detector SHALL be one sub-module, spi_sync_edge, instantiated once per input (sclk, mosi, cs).

Verification
REQ-035 Write frame cmd 0x80, addr 0x1234, data 0xBEEF -> one bus_we pulse with bus_addr 0x1234, bus_wdata 0xBEEF; bus_re never asserted.
REQ-036 Read frame cmd 0x00, addr 0x5555, bus responds 0xA5C3 with rvalid 3 cycles after bus_re -> master captures 0xA5C3; rd_late = 0.
REQ-037 Read with bus_rvalid withheld past the first data sclk edge -> master captures 0x0000, rd_late = 1 and stays 1 until reset.
REQ-038 cs deasserted after 20 bits of a write frame -> no bus_we, FSM returns to IDLE; a following full write 0x80/0x0001/0x0002 completes correctly.
REQ-039 Reset pulsed in the middle of the ADDR phase -> all outputs 0 immediately; the next frame decodes correctly.
REQ-040 Back-to-back frames (write, then read of the same address, 2 sclk periods of cs high between them) with sclk = clk/8 -> exactly one bus_we and one bus_re in order.
